// File: rtl/shiftadd_operand_prep_if.sv
// Operand/result bundle between the request source and the shift-add operand feeder.
interface shiftadd_operand_prep_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BL_W   = 32
);
  logic                  start_i;
  logic [DATA_W-1:0]     a_i;
  logic [DATA_W-1:0]     b_i;
  logic [DATA_W-1:0]     m_i;
  logic                  ready_o;
  logic                  busy_o;
  logic [2*DATA_W-1:0]   x_o;
  logic [DATA_W-1:0]     m_o;
  logic [BL_W-1:0]       m_bl_o;
  logic                  start_o;
  logic                  err_o;

  modport master (
    output start_i, a_i, b_i, m_i,
    input  ready_o, busy_o, x_o, m_o, m_bl_o, start_o, err_o
  );

  modport slave (
    input  start_i, a_i, b_i, m_i,
    output ready_o, busy_o, x_o, m_o, m_bl_o, start_o, err_o
  );
endinterface

// File: rtl/shiftadd_operand_prep.sv
// Forms x = a*b bit-serially and the bit length of m, then pulses start_o for the reducer.
module shiftadd_operand_prep #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BL_W   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  shiftadd_operand_prep_if.slave bus
);
  localparam int unsigned X_W   = 2 * DATA_W;
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    ISSUE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [X_W-1:0]    a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [X_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BL_W-1:0]   bl_q, bl_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [DATA_W-1:0] mo_q, mo_d;
  logic [BL_W-1:0]   mbl_q, mbl_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [X_W-1:0]    acc_step;
  logic [BL_W-1:0]   bl_step;

  // Next state, datapath updates and registered-output values.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    bl_d     = bl_q;
    x_d      = x_q;
    mo_d     = mo_q;
    mbl_d    = mbl_q;
    start_d  = 1'b0;
    err_d    = err_q;
    acc_step = acc_q + (b_q[cnt_q] ? (a_q << cnt_q) : '0);
    bl_step  = m_q[cnt_q] ? (BL_W'(cnt_q) + BL_W'(1)) : bl_q;

    unique case (state_q)
      IDLE, HOLD: begin
        if (bus.start_i) begin
          a_d     = X_W'(bus.a_i);
          b_d     = bus.b_i;
          m_d     = bus.m_i;
          acc_d   = '0;
          cnt_d   = '0;
          bl_d    = '0;
          err_d   = 1'b0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_step;
        bl_d  = bl_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          if (m_q == '0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            x_d     = acc_step;
            mo_d    = m_q;
            mbl_d   = bl_step;
            start_d = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = HOLD;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == HOLD);
    busy_d  = (state_d == MUL) || (state_d == ISSUE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bl_q    <= '0;
      x_q     <= '0;
      mo_q    <= '0;
      mbl_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bl_q    <= bl_d;
      x_q     <= x_d;
      mo_q    <= mo_d;
      mbl_q   <= mbl_d;
      start_q <= start_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.x_o     = x_q;
  assign bus.m_o     = mo_q;
  assign bus.m_bl_o  = mbl_q;
  assign bus.start_o = start_q;
  assign bus.err_o   = err_q;
  assign bus.ready_o = ready_q;
  assign bus.busy_o  = busy_q;
endmodule

// File: tb/tb_shiftadd_operand_prep.sv
// Directed bench for shiftadd_operand_prep with hand-computed expectations.
module tb_shiftadd_operand_prep;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   first;
  int   pulses;
  int   seen;

  shiftadd_operand_prep_if #(.DATA_W(32), .BL_W(32)) bus ();

  shiftadd_operand_prep #(.DATA_W(32), .BL_W(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle; returns in cycle 1 (first MUL cycle).
  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m);
    @(negedge clk);
    bus.a_i     = a;
    bus.b_i     = b;
    bus.m_i     = m;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // Watch start_o for a bounded number of cycles, optionally poking start_i with junk operands.
  task automatic run_wait(input int limit, input int poke_a, input int poke_b,
                          output int first_c, output int n_pulse);
    first_c = 0;
    n_pulse = 0;
    for (int c = 1; c <= limit; c++) begin
      if (bus.start_o) begin
        n_pulse++;
        if (first_c == 0) first_c = c;
      end
      if (c == poke_a || c == poke_b) begin
        bus.start_i = 1'b1;
        bus.a_i     = 32'hDEAD_0000 + 32'(c);
        bus.b_i     = 32'hBEEF;
        bus.m_i     = 32'h3;
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
    end
    bus.start_i = 1'b0;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.m_i     = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", 64'(bus.ready_o), 64'd1);
    check("rst_busy",  64'(bus.busy_o),  64'd0);
    check("rst_x",     bus.x_o,          64'd0);
    check("rst_m",     64'(bus.m_o),     64'd0);
    check("rst_mbl",   64'(bus.m_bl_o),  64'd0);
    check("rst_start", 64'(bus.start_o), 64'd0);
    check("rst_err",   64'(bus.err_o),   64'd0);
    rst_n = 1'b1;

    // Basic product and latency
    do_start(32'd3, 32'd5, 32'd7);
    check("a_busy",  64'(bus.busy_o),  64'd1);
    check("a_ready", 64'(bus.ready_o), 64'd0);
    check("a_x_stable", bus.x_o,       64'd0);
    run_wait(40, 0, 0, first, pulses);
    check("a_first",  64'(first),      64'd33);
    check("a_pulses", 64'(pulses),     64'd1);
    check("a_x",      bus.x_o,         64'hF);
    check("a_m",      64'(bus.m_o),    64'd7);
    check("a_mbl",    64'(bus.m_bl_o), 64'd3);
    check("a_ready_hold", 64'(bus.ready_o), 64'd1);

    // All-ones operands, accepted from HOLD
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_wait(40, 0, 0, first, pulses);
    check("ones_first",  64'(first),      64'd33);
    check("ones_pulses", 64'(pulses),     64'd1);
    check("ones_x",      bus.x_o,         64'hFFFF_FFFE_0000_0001);
    check("ones_mbl",    64'(bus.m_bl_o), 64'd32);

    // Fermat modulus
    do_start(32'h1234_5678, 32'h9ABC_DEF0, 32'h0001_0001);
    run_wait(40, 0, 0, first, pulses);
    check("ferm_x",   bus.x_o,         64'h0B00_EA4E_242D_2080);
    check("ferm_m",   64'(bus.m_o),    64'h1_0001);
    check("ferm_mbl", 64'(bus.m_bl_o), 64'd17);

    // start_i during ISSUE is not accepted
    do_start(32'd2, 32'd3, 32'd5);
    seen = 0;
    for (int c = 1; c <= 60 && seen == 0; c++) begin
      if (bus.start_o) seen = 1;
      else @(negedge clk);
    end
    check("iss_seen", 64'(seen), 64'd1);
    bus.a_i     = 32'd9;
    bus.m_i     = 32'd11;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("iss_busy",  64'(bus.busy_o),  64'd0);
    check("iss_ready", 64'(bus.ready_o), 64'd1);
    check("iss_x",     bus.x_o,          64'd6);
    check("iss_mbl",   64'(bus.m_bl_o),  64'd3);

    // Zero modulus: error, no pulse, outputs untouched
    do_start(32'd1, 32'd1, 32'd0);
    run_wait(40, 0, 0, first, pulses);
    check("m0_pulses", 64'(pulses),      64'd0);
    check("m0_err",    64'(bus.err_o),   64'd1);
    check("m0_ready",  64'(bus.ready_o), 64'd1);
    check("m0_busy",   64'(bus.busy_o),  64'd0);
    check("m0_x",      bus.x_o,          64'd6);

    // Next valid request clears the error
    do_start(32'd4, 32'd4, 32'd9);
    check("clr_err", 64'(bus.err_o), 64'd0);
    run_wait(40, 0, 0, first, pulses);
    check("clr_pulses", 64'(pulses),      64'd1);
    check("clr_x",      bus.x_o,          64'd16);
    check("clr_mbl",    64'(bus.m_bl_o),  64'd4);

    // Requests while busy are ignored
    do_start(32'd6, 32'd7, 32'h20);
    run_wait(40, 5, 20, first, pulses);
    check("ign_first",  64'(first),      64'd33);
    check("ign_pulses", 64'(pulses),     64'd1);
    check("ign_x",      bus.x_o,         64'd42);
    check("ign_m",      64'(bus.m_o),    64'h20);
    check("ign_mbl",    64'(bus.m_bl_o), 64'd6);

    // Reset mid-MUL aborts with no pulse
    do_start(32'd3, 32'd5, 32'd7);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_ready", 64'(bus.ready_o), 64'd1);
    check("mrst_busy",  64'(bus.busy_o),  64'd0);
    check("mrst_x",     bus.x_o,          64'd0);
    check("mrst_m",     64'(bus.m_o),     64'd0);
    check("mrst_mbl",   64'(bus.m_bl_o),  64'd0);
    check("mrst_start", 64'(bus.start_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_wait(45, 0, 0, first, pulses);
    check("mrst_pulses", 64'(pulses), 64'd0);
    check("mrst_x_after", bus.x_o,    64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
